// File: rtl/uart8_receiver.sv
// Oversampled UART receiver: 2-flop input sync, mid-bit start validation, LSB-first data, stop check.
// Optional even-parity bit and perr strobe when UART_PARITY_EN is defined.
module uart8_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] out,
  output logic                 done,
  output logic                 busy,
`ifdef UART_PARITY_EN
  output logic                 perr,
`endif
  output logic                 err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic                 sync1;
  logic                 rxs;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_PARITY_EN
  logic                 par;
`endif

  // Nonzero when data plus the even-parity bit has odd weight.
  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  // Synchroniser, frame FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
`ifdef UART_PARITY_EN
      par   <= 1'b0;
      perr  <= 1'b0;
`endif
    end else begin
      sync1 <= in;
      rxs   <= sync1;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef UART_PARITY_EN
      perr  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (rxs) begin
            armed <= 1'b1;
          end
          // Only a falling edge seen after the line was high may start a frame.
          if (en && armed && !rxs) begin
            state <= S_START;
            cnt   <= '0;
            busy  <= 1'b1;
            armed <= 1'b0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            cnt   <= '0;
            if (idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (cnt == BIT_LAST) begin
            par   <= rxs;
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            // Return to idle at mid stop bit so a following start bit is not missed.
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= !rxs;
`ifdef UART_PARITY_EN
            perr  <= parity_fail(shreg, par);
            if (rxs && !parity_fail(shreg, par)) begin
              out <= shreg;
            end
`else
            if (rxs) begin
              out <= shreg;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
